// File: rtl/command_frame_decoder.sv
// Byte-stream command frame decoder driving per-pipeline write/update/alloc/reset strobes.
// Define CMD_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module command_frame_decoder #(
    parameter int unsigned N_PIPELINES    = 2,
    parameter int unsigned N_BLOCKS       = 32,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned INSTR_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    localparam int unsigned BLK_W         = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                in_byte,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [BLK_W-1:0]          block_target,
    output logic [REG_ADDR_WIDTH-1:0] reg_target,
    output logic [INSTR_WIDTH-1:0]    instr_out,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [N_PIPELINES-1:0]    instr_write,
    output logic [N_PIPELINES-1:0]    reg_write,
    output logic [N_PIPELINES-1:0]    reg_update,
    output logic [N_PIPELINES-1:0]    alloc_delay,
    output logic [N_PIPELINES-1:0]    pipeline_reset,
    output logic                      swap_req,
    input  logic                      swap_busy,
    output logic                      status_valid,
    output logic [2:0]                status_code,
    output logic                      busy
);

`ifdef CMD_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    localparam int unsigned DATA_BYTES  = DATA_WIDTH / 8;
    localparam int unsigned INSTR_BYTES = INSTR_WIDTH / 8;
    localparam int unsigned MAX_BYTES   = (DATA_BYTES > INSTR_BYTES) ? DATA_BYTES : INSTR_BYTES;
    localparam int unsigned CNT_W       = $clog2(MAX_BYTES + 1);
    localparam int unsigned TMR_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TMO_LAST    = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    localparam logic [3:0] CMD_WRITE_INSTR = 4'd1;
    localparam logic [3:0] CMD_WRITE_REG   = 4'd2;
    localparam logic [3:0] CMD_UPDATE_REG  = 4'd3;
    localparam logic [3:0] CMD_ALLOC_DELAY = 4'd4;
    localparam logic [3:0] CMD_SWAP        = 4'd5;
    localparam logic [3:0] CMD_RESET_PIPE  = 4'd6;

    localparam logic [2:0] STS_OK           = 3'd0;
    localparam logic [2:0] STS_BAD_OPCODE   = 3'd1;
    localparam logic [2:0] STS_BAD_PIPELINE = 3'd2;
    localparam logic [2:0] STS_BAD_CHECKSUM = 3'd3;
    localparam logic [2:0] STS_TIMEOUT      = 3'd4;
    localparam logic [2:0] STS_BAD_TARGET   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE, ST_GET_BLOCK, ST_GET_REG, ST_GET_DATA,
        ST_GET_INSTR, ST_GET_CSUM, ST_EXEC, ST_SWAP_WAIT
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                cmd_q, cmd_d;
    logic [3:0]                pipe_q, pipe_d;
    logic                      pipe_err_q, pipe_err_d;
    logic                      tgt_err_q, tgt_err_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [7:0]                csum_q, csum_d;
    logic [TMR_W-1:0]          tmr_q, tmr_d;
    logic                      seen_busy_q, seen_busy_d;
    logic [BLK_W-1:0]          block_q, block_d;
    logic [REG_ADDR_WIDTH-1:0] reg_q, reg_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
    logic [N_PIPELINES-1:0]    iw_q, iw_d, rw_q, rw_d, ru_q, ru_d, ad_q, ad_d, pr_q, pr_d;
    logic                      swap_req_q, swap_req_d;
    logic                      status_valid_q, status_valid_d;
    logic [2:0]                status_code_q, status_code_d;
    logic                      in_ready_q, in_ready_d;
    logic                      busy_q, busy_d;

    logic                      accept;
    logic                      last_byte;
    logic                      csum_bad;
    logic                      tick;
    logic                      is_get;
    logic [N_PIPELINES-1:0]    sel;

    assign accept = in_valid && in_ready_q;

    // Next-state, field capture and strobe generation
    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        pipe_d         = pipe_q;
        pipe_err_d     = pipe_err_q;
        tgt_err_d      = tgt_err_q;
        cnt_d          = cnt_q;
        csum_d         = csum_q;
        tmr_d          = tmr_q;
        seen_busy_d    = seen_busy_q;
        block_d        = block_q;
        reg_d          = reg_q;
        data_d         = data_q;
        instr_d        = instr_q;
        iw_d           = '0;
        rw_d           = '0;
        ru_d           = '0;
        ad_d           = '0;
        pr_d           = '0;
        swap_req_d     = 1'b0;
        status_valid_d = 1'b0;
        status_code_d  = STS_OK;
        last_byte      = 1'b0;
        csum_bad       = 1'b0;
        tick           = 1'b0;
        sel            = '0;
        is_get         = state_q inside {ST_GET_BLOCK, ST_GET_REG, ST_GET_DATA,
                                         ST_GET_INSTR, ST_GET_CSUM};

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_d      = in_byte[7:4];
                    pipe_d     = in_byte[3:0];
                    pipe_err_d = 32'(in_byte[3:0]) >= N_PIPELINES;
                    tgt_err_d  = 1'b0;
                    cnt_d      = '0;
                    csum_d     = in_byte;
                    case (in_byte[7:4])
                        CMD_WRITE_INSTR, CMD_WRITE_REG, CMD_UPDATE_REG: state_d = ST_GET_BLOCK;
                        CMD_ALLOC_DELAY:                                state_d = ST_GET_DATA;
                        CMD_SWAP, CMD_RESET_PIPE:                       last_byte = 1'b1;
                        default: begin
                            status_valid_d = 1'b1;
                            status_code_d  = STS_BAD_OPCODE;
                        end
                    endcase
                end
            end
            ST_GET_BLOCK: begin
                if (accept) begin
                    block_d   = BLK_W'(in_byte);
                    tgt_err_d = 32'(in_byte) >= N_BLOCKS;
                    state_d   = (cmd_q == CMD_WRITE_INSTR) ? ST_GET_INSTR : ST_GET_REG;
                end
            end
            ST_GET_REG: begin
                if (accept) begin
                    reg_d   = REG_ADDR_WIDTH'(in_byte);
                    state_d = ST_GET_DATA;
                end
            end
            ST_GET_DATA: begin
                if (accept) begin
                    data_d    = DATA_WIDTH'({data_q, in_byte});
                    cnt_d     = cnt_q + 1'b1;
                    last_byte = (cnt_q == CNT_W'(DATA_BYTES - 1));
                end
            end
            ST_GET_INSTR: begin
                if (accept) begin
                    instr_d   = INSTR_WIDTH'({instr_q, in_byte});
                    cnt_d     = cnt_q + 1'b1;
                    last_byte = (cnt_q == CNT_W'(INSTR_BYTES - 1));
                end
            end
            ST_GET_CSUM: begin
                if (accept) begin
                    last_byte = 1'b1;
                    csum_bad  = (csum_q ^ in_byte) != 8'h00;
                end
            end
            ST_EXEC: begin
                state_d     = swap_req_q ? ST_SWAP_WAIT : ST_IDLE;
                seen_busy_d = 1'b0;
            end
            ST_SWAP_WAIT: begin
                if (!seen_busy_q) begin
                    if (swap_busy) seen_busy_d = 1'b1;
                    else           tick = 1'b1;
                end else if (!swap_busy) begin
                    state_d        = ST_IDLE;
                    status_valid_d = 1'b1;
                    status_code_d  = STS_OK;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (is_get) begin
            tick = !accept;
            if (accept) csum_d = csum_q ^ in_byte;
        end

        // Frame complete: either collect the checksum byte or execute
        if (last_byte) begin
            if (CSUM_EN && state_q != ST_GET_CSUM) begin
                state_d = ST_GET_CSUM;
            end else begin
                state_d        = ST_EXEC;
                status_valid_d = 1'b1;
                sel            = N_PIPELINES'(1) << pipe_d;
                if (csum_bad) begin
                    status_code_d = STS_BAD_CHECKSUM;
                end else if (cmd_d == CMD_SWAP) begin
                    swap_req_d     = 1'b1;
                    status_valid_d = 1'b0;
                end else if (pipe_err_d) begin
                    status_code_d = STS_BAD_PIPELINE;
                end else if (tgt_err_d) begin
                    status_code_d = STS_BAD_TARGET;
                end else begin
                    case (cmd_d)
                        CMD_WRITE_INSTR: iw_d = sel;
                        CMD_WRITE_REG:   rw_d = sel;
                        CMD_UPDATE_REG:  ru_d = sel;
                        CMD_ALLOC_DELAY: ad_d = sel;
                        CMD_RESET_PIPE:  pr_d = sel;
                        default:         ;
                    endcase
                end
            end
        end

        if (tick && TIMEOUT_CYCLES != 0 && tmr_q == TMR_W'(TMO_LAST)) begin
            state_d        = ST_IDLE;
            status_valid_d = 1'b1;
            status_code_d  = STS_TIMEOUT;
        end

        if (accept || state_d != state_q) tmr_d = '0;
        else if (tick)                     tmr_d = tmr_q + 1'b1;

        in_ready_d = state_d inside {ST_IDLE, ST_GET_BLOCK, ST_GET_REG, ST_GET_DATA,
                                     ST_GET_INSTR, ST_GET_CSUM};
        busy_d     = state_d != ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cmd_q          <= '0;
            pipe_q         <= '0;
            pipe_err_q     <= 1'b0;
            tgt_err_q      <= 1'b0;
            cnt_q          <= '0;
            csum_q         <= '0;
            tmr_q          <= '0;
            seen_busy_q    <= 1'b0;
            block_q        <= '0;
            reg_q          <= '0;
            data_q         <= '0;
            instr_q        <= '0;
            iw_q           <= '0;
            rw_q           <= '0;
            ru_q           <= '0;
            ad_q           <= '0;
            pr_q           <= '0;
            swap_req_q     <= 1'b0;
            status_valid_q <= 1'b0;
            status_code_q  <= '0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            pipe_q         <= pipe_d;
            pipe_err_q     <= pipe_err_d;
            tgt_err_q      <= tgt_err_d;
            cnt_q          <= cnt_d;
            csum_q         <= csum_d;
            tmr_q          <= tmr_d;
            seen_busy_q    <= seen_busy_d;
            block_q        <= block_d;
            reg_q          <= reg_d;
            data_q         <= data_d;
            instr_q        <= instr_d;
            iw_q           <= iw_d;
            rw_q           <= rw_d;
            ru_q           <= ru_d;
            ad_q           <= ad_d;
            pr_q           <= pr_d;
            swap_req_q     <= swap_req_d;
            status_valid_q <= status_valid_d;
            status_code_q  <= status_code_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign block_target   = block_q;
    assign reg_target     = reg_q;
    assign instr_out      = instr_q;
    assign data_out       = data_q;
    assign instr_write    = iw_q;
    assign reg_write      = rw_q;
    assign reg_update     = ru_q;
    assign alloc_delay    = ad_q;
    assign pipeline_reset = pr_q;
    assign swap_req       = swap_req_q;
    assign status_valid   = status_valid_q;
    assign status_code    = status_code_q;
    assign busy           = busy_q;

endmodule

// File: doc/command_frame_decoder.md
Name: command_frame_decoder

Overview:
Parametrised byte-stream command decoder. It sits between the host byte link and N_PIPELINES DSP pipelines. It parses framed commands, including a per-frame pipeline index, and drives one-cycle write/update/alloc/reset strobes per pipeline. It adds a valid/ready byte handshake, an inter-byte timeout, per-frame status reporting and an optional frame checksum.

Parameters:
N_PIPELINES, 2, number of target pipelines (1..16); index carried in the opcode low nibble.
N_BLOCKS, 32, blocks per pipeline; block_target width = $clog2(N_BLOCKS).
REG_ADDR_WIDTH, 4, block register address width (≤8).
DATA_WIDTH, 16, register/alloc data width; multiple of 8.
INSTR_WIDTH, 32, block instruction width; multiple of 8.
TIMEOUT_CYCLES, 1000000, idle cycles allowed mid-frame or in swap wait; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_byte  in  8  stream byte
in_valid  in  1  in_byte valid
in_ready  out  1  decoder can accept; a byte transfers when in_valid && in_ready
block_target  out  clog2(N_BLOCKS)  block index
reg_target  out  REG_ADDR_WIDTH  register index
instr_out  out  INSTR_WIDTH  instruction word
data_out  out  DATA_WIDTH  data word
instr_write  out  N_PIPELINES  per-pipeline instruction write strobe
reg_write  out  N_PIPELINES  per-pipeline register write strobe
reg_update  out  N_PIPELINES  per-pipeline register update strobe
alloc_delay  out  N_PIPELINES  per-pipeline SRAM delay alloc strobe
pipeline_reset  out  N_PIPELINES  per-pipeline reset strobe
swap_req  out  1  swap request pulse
swap_busy  in  1  pipelines swapping
status_valid  out  1  one-cycle frame-complete pulse
status_code  out  3  0 OK, 1 BAD_OPCODE, 2 BAD_PIPELINE, 3 BAD_CHECKSUM, 4 TIMEOUT, 5 BAD_TARGET
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0 (in_ready also 0 in the reset cycle). State goes to IDLE and any partial frame is discarded. From the following cycle in_ready=1.
- Opcode byte: [7:4] command, [3:0] pipeline index p.
- Command 1 WRITE_INSTR fields: block, instr bytes.
- Command 2 WRITE_REG and command 3 UPDATE_REG fields: block, reg, data bytes.
- Command 4 ALLOC_DELAY fields: data bytes.
- Command 5 SWAP and command 6 RESET_PIPELINE: no fields.
- Multi-byte fields are MSB first and shifted in. Block and reg bytes are truncated to port width.
- States: IDLE, GET_BLOCK, GET_REG, GET_DATA, GET_INSTR, [GET_CSUM], EXEC, SWAP_WAIT.
- in_ready=1 only in IDLE and GET_* states. One byte accepted per cycle, with no dead cycles between accepted bytes.
- Last frame byte accepted in cycle T: EXEC in T+1.
  - In EXEC the selected strobe bit p is high for exactly one cycle, status_valid=1 and status_code=0.
  - in_ready=0 in EXEC; IDLE from T+2.
- Unknown command (0, 7..15): status 1 in the cycle after the opcode, return to IDLE. The next byte is treated as an opcode.
- p ≥ N_PIPELINES: the full frame is consumed, then status 2 in EXEC with no strobe. Block byte ≥ N_BLOCKS: same handling, status 5. If both apply, pipeline error takes priority.
- SWAP:
  - swap_req pulses in EXEC, then the decoder enters SWAP_WAIT with in_ready=0.
  - It waits for swap_busy to rise, then fall. status_valid/OK pulses in the cycle after swap_busy is first seen low again, returning to IDLE.
  - The p nibble is ignored for SWAP.
- Timeout: a counter clears on each accepted byte and on state entry. It increments in GET_* states, and in SWAP_WAIT before swap_busy rises.
  - On reaching TIMEOUT_CYCLES: status 4, no strobe, IDLE next cycle.
- Field registers hold their last value between frames.
- Strobes are never asserted for errored frames.
- busy = (state != IDLE).

Optional Feature:
CMD_CHECKSUM_EN:
- Defined: every frame, including SWAP and RESET frames, carries one trailing byte such that the XOR of all frame bytes equals 0x00.
  - Mismatch: status 3 and no strobe (or no swap_req).
  - For SWAP, swap_req pulses only after a good checksum.
  - Unknown opcodes still abort immediately.
- Undefined: no checksum byte and status 3 is never produced.

Test Plan:
- Bytes 21,05,03,AB,CD back-to-back → cycle after CD: reg_write=2'b10, block_target=5, reg_target=3, data_out=ABCD, status OK; in_ready low that cycle only.
- Bytes 10,1F,DE,AD,BE,EF → instr_write=2'b01, block_target=31, instr_out=DEADBEEF; then F0 → status 1 next cycle, no strobes.
- Byte 63 (p=3, N_PIPELINES=2) → status 2, pipeline_reset=0. Byte 20,40,... → after full frame consumed, status 5.
- TIMEOUT_CYCLES=100: bytes 20,05 then idle → status 4 after 100 cycles. Then byte 60 → pipeline_reset=2'b01. Also assert reset mid-frame → no strobe, in_ready=1 after.
- Byte 50 → swap_req pulse; swap_busy high from +3 for 10 cycles → status OK the cycle after it falls; in_ready=0 throughout. Separately, swap_busy never rises → TIMEOUT.
- With CMD_CHECKSUM_EN: 60,60 → pipeline_reset=01, OK; 60,61 → status 3, no strobe.
